// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with MEM/WB forwarding and load-use bubble insertion
// Optional performance counters (bubbleCount, flushCount, clrCounts) are enabled by ID_EX_PERF_CNT_EN.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic [REG_AW-1:0] idRd,
  input  logic [DATA_W-1:0] idRsData,
  input  logic [DATA_W-1:0] idRtData,
  input  logic [DATA_W-1:0] idImm,
  input  logic              idAluSrc,
  input  logic              idRegDst,
  input  logic [2:0]        idAluOp,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic              idMemWrite,
  input  logic              stall,
  input  logic              flush,
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] memRd,
  input  logic [DATA_W-1:0] memResult,
  input  logic              wbRegWrite,
  input  logic [REG_AW-1:0] wbRd,
  input  logic [DATA_W-1:0] wbResult,
`ifdef ID_EX_PERF_CNT_EN
  input  logic              clrCounts,
  output logic [31:0]       bubbleCount,
  output logic [31:0]       flushCount,
`endif
  output logic [DATA_W-1:0] aluInA,
  output logic [DATA_W-1:0] aluInB,
  output logic [2:0]        aluOp,
  output logic              exValid,
  output logic              exRegWrite,
  output logic              exMemRead,
  output logic              exMemWrite,
  output logic [REG_AW-1:0] exWriteReg,
  output logic [DATA_W-1:0] exStoreData,
  output logic              loadUseHazard
);

  logic [REG_AW-1:0] exRs;
  logic [REG_AW-1:0] exRt;
  logic [DATA_W-1:0] exRsData;
  logic [DATA_W-1:0] exRtData;
  logic [DATA_W-1:0] exImm;
  logic              exAluSrc;
  logic [DATA_W-1:0] fwdRs;
  logic [DATA_W-1:0] fwdRt;

  // On flush or bubble, only the valid/control bits are cleared; data fields are don't-care and hold.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      exValid    <= 1'b0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exMemWrite <= 1'b0;
      aluOp      <= 3'b000;
      exWriteReg <= '0;
      exRs       <= '0;
      exRt       <= '0;
      exRsData   <= '0;
      exRtData   <= '0;
      exImm      <= '0;
      exAluSrc   <= 1'b0;
    end else if (flush) begin
      exValid    <= 1'b0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exMemWrite <= 1'b0;
    end else if (!stall) begin
      if (loadUseHazard) begin
        exValid    <= 1'b0;
        exRegWrite <= 1'b0;
        exMemRead  <= 1'b0;
        exMemWrite <= 1'b0;
      end else begin
        exValid    <= idValid;
        exRegWrite <= idRegWrite & idValid;
        exMemRead  <= idMemRead & idValid;
        exMemWrite <= idMemWrite & idValid;
        aluOp      <= idAluOp;
        exWriteReg <= idRegDst ? idRd : idRt;
        exRs       <= idRs;
        exRt       <= idRt;
        exRsData   <= idRsData;
        exRtData   <= idRtData;
        exImm      <= idImm;
        exAluSrc   <= idAluSrc;
      end
    end
  end

  // MEM is the younger producer, so it wins over WB; r0 is hardwired and never forwarded.
  always_comb begin
    fwdRs = exRsData;
    if (memRegWrite && memRd != '0 && memRd == exRs)
      fwdRs = memResult;
    else if (wbRegWrite && wbRd != '0 && wbRd == exRs)
      fwdRs = wbResult;
  end

  always_comb begin
    fwdRt = exRtData;
    if (memRegWrite && memRd != '0 && memRd == exRt)
      fwdRt = memResult;
    else if (wbRegWrite && wbRd != '0 && wbRd == exRt)
      fwdRt = wbResult;
  end

  assign aluInA      = fwdRs;
  assign exStoreData = fwdRt;
  assign aluInB      = exAluSrc ? exImm : fwdRt;

  // rt match counts even for immediate-type consumers: conservative by design.
  assign loadUseHazard = exValid & exMemRead & (exWriteReg != '0) & idValid &
                         ((exWriteReg == idRs) | (exWriteReg == idRt));

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bubbleCount <= '0;
      flushCount  <= '0;
    end else if (clrCounts) begin
      bubbleCount <= '0;
      flushCount  <= '0;
    end else begin
      if (flush)
        flushCount <= flushCount + 32'd1;
      if (!flush && !stall && loadUseHazard)
        bubbleCount <= bubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for id_ex_operand_stage
// Stimulus queues expected values; a monitor pops and compares them on each sample event.
module tb_id_ex_operand_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam int S_A = 0, S_B = 1, S_ST = 2, S_OP = 3, S_VAL = 4, S_RW = 5,
                 S_LUH = 6, S_MR = 7, S_WR = 8, S_BC = 9, S_FC = 10;

  logic clk = 1'b0, clkEn = 1'b0, rstN = 1'b1;
  logic idValid = 0, idAluSrc = 0, idRegDst = 0, idRegWrite = 0, idMemRead = 0, idMemWrite = 0;
  logic [REG_AW-1:0] idRs = 0, idRt = 0, idRd = 0, memRd = 0, wbRd = 0;
  logic [DATA_W-1:0] idRsData = 0, idRtData = 0, idImm = 0, memResult = 0, wbResult = 0;
  logic [2:0] idAluOp = 0;
  logic stall = 0, flush = 0, memRegWrite = 0, wbRegWrite = 0, clrCounts = 0;
  logic [DATA_W-1:0] aluInA, aluInB, exStoreData;
  logic [2:0] aluOp;
  logic exValid, exRegWrite, exMemRead, exMemWrite, loadUseHazard;
  logic [REG_AW-1:0] exWriteReg;
  logic [31:0] bubbleCount, flushCount;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;
  chk_t q[$];
  event smp;

  id_ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rstN(rstN), .idValid(idValid), .idRs(idRs), .idRt(idRt), .idRd(idRd),
    .idRsData(idRsData), .idRtData(idRtData), .idImm(idImm), .idAluSrc(idAluSrc),
    .idRegDst(idRegDst), .idAluOp(idAluOp), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
    .idMemWrite(idMemWrite), .stall(stall), .flush(flush), .memRegWrite(memRegWrite),
    .memRd(memRd), .memResult(memResult), .wbRegWrite(wbRegWrite), .wbRd(wbRd),
    .wbResult(wbResult),
`ifdef ID_EX_PERF_CNT_EN
    .clrCounts(clrCounts), .bubbleCount(bubbleCount), .flushCount(flushCount),
`endif
    .aluInA(aluInA), .aluInB(aluInB), .aluOp(aluOp), .exValid(exValid),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exWriteReg(exWriteReg), .exStoreData(exStoreData), .loadUseHazard(loadUseHazard)
  );

`ifndef ID_EX_PERF_CNT_EN
  assign bubbleCount = 32'd0;
  assign flushCount  = 32'd0;
`endif

  initial forever #5 if (clkEn) clk = ~clk;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_A:   return aluInA;
      S_B:   return aluInB;
      S_ST:  return exStoreData;
      S_OP:  return {29'd0, aluOp};
      S_VAL: return {31'd0, exValid};
      S_RW:  return {31'd0, exRegWrite};
      S_LUH: return {31'd0, loadUseHazard};
      S_MR:  return {31'd0, exMemRead};
      S_WR:  return {27'd0, exWriteReg};
      S_BC:  return bubbleCount;
      S_FC:  return flushCount;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  initial begin : monitor
    chk_t e;
    logic [31:0] act;
    forever begin
      @smp;
      while (q.size() > 0) begin
        e = q.pop_front();
        act = actual(e.sel);
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    chk_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> smp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic regDst, input logic aluSrc, input logic [31:0] imm,
                          input logic [2:0] op, input logic rw, input logic mr);
    idValid = v; idRs = rs; idRsData = rsd; idRt = rt; idRtData = rtd; idRd = rd;
    idRegDst = regDst; idAluSrc = aluSrc; idImm = imm; idAluOp = op;
    idRegWrite = rw; idMemRead = mr; idMemWrite = 1'b0;
  endtask

  initial begin : stimulus
    #2 rstN = 1'b0;
    expect_val("rst_exValid", S_VAL, 0);
    expect_val("rst_aluOp", S_OP, 0);
    expect_val("rst_exRegWrite", S_RW, 0);
    expect_val("rst_aluInA", S_A, 0);
    expect_val("rst_luh", S_LUH, 0);
    sample();
    checks++;
    if (exValid !== 1'b0) begin
      failures++;
      $display("FAIL inline_rst_exValid actual=%h required=%h", exValid, 1'b0);
    end
    clkEn = 1'b1;
    @(negedge clk);
    rstN = 1'b1;

    drive_id(1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1, 0, 32'd0, 3'b000, 1, 0);
    tick();
    expect_val("add_aluInA", S_A, 5);
    expect_val("add_aluInB", S_B, 7);
    expect_val("add_aluOp", S_OP, 0);
    expect_val("add_exValid", S_VAL, 1);
    expect_val("add_exRegWrite", S_RW, 1);
    expect_val("add_exWriteReg", S_WR, 3);
    expect_val("add_storeData", S_ST, 7);
    sample();
    checks++;
    if (aluInA !== 32'd5) begin
      failures++;
      $display("FAIL inline_add_aluInA actual=%h required=%h", aluInA, 32'd5);
    end
    checks++;
    if (aluInB !== 32'd7) begin
      failures++;
      $display("FAIL inline_add_aluInB actual=%h required=%h", aluInB, 32'd7);
    end

    drive_id(1, 5'd3, 32'h33, 5'd5, 32'h55, 5'd9, 1, 0, 32'd0, 3'b001, 1, 0);
    tick();
    memRegWrite = 1; memRd = 5'd3; memResult = 32'h11;
    wbRegWrite = 1; wbRd = 5'd3; wbResult = 32'h22;
    expect_val("fwd_mem_over_wb", S_A, 32'h11);
    expect_val("fwd_rt_nomatch", S_ST, 32'h55);
    expect_val("fwd_aluOp_sub", S_OP, 1);
    sample();
    checks++;
    if (aluInA !== 32'h11) begin
      failures++;
      $display("FAIL inline_fwd_mem_over_wb actual=%h required=%h", aluInA, 32'h11);
    end
    memRegWrite = 0;
    expect_val("fwd_wb_only", S_A, 32'h22);
    sample();
    checks++;
    if (aluInA !== 32'h22) begin
      failures++;
      $display("FAIL inline_fwd_wb_only actual=%h required=%h", aluInA, 32'h22);
    end
    wbRegWrite = 0;
    expect_val("fwd_none", S_A, 32'h33);
    sample();
    memRegWrite = 1; memRd = 5'd5;
    expect_val("fwd_rt_mem", S_ST, 32'h11);
    expect_val("fwd_rt_mem_b", S_B, 32'h11);
    expect_val("fwd_rs_indep", S_A, 32'h33);
    sample();

    drive_id(1, 5'd0, 32'd0, 5'd6, 32'h66, 5'd10, 1, 1, 32'hFFFFFFFC, 3'b010, 1, 0);
    tick();
    memRegWrite = 1; memRd = 5'd0; memResult = 32'hFF;
    wbRegWrite = 1; wbRd = 5'd6; wbResult = 32'h77;
    expect_val("r0_no_fwd", S_A, 0);
    expect_val("imm_aluInB", S_B, 32'hFFFFFFFC);
    expect_val("imm_storeData_fwd", S_ST, 32'h77);
    expect_val("imm_aluOp_and", S_OP, 2);
    sample();
    checks++;
    if (aluInA !== 32'd0) begin
      failures++;
      $display("FAIL inline_r0_no_fwd actual=%h required=%h", aluInA, 32'd0);
    end
    memRegWrite = 0; wbRegWrite = 0;

    drive_id(1, 5'd1, 32'h100, 5'd4, 32'd0, 5'd0, 0, 1, 32'd0, 3'b000, 1, 1);
    tick();
    drive_id(1, 5'd4, 32'h44, 5'd7, 32'h70, 5'd8, 1, 0, 32'd0, 3'b000, 1, 0);
    expect_val("lu_hazard", S_LUH, 1);
    expect_val("lu_exWriteReg", S_WR, 4);
    sample();
    checks++;
    if (loadUseHazard !== 1'b1) begin
      failures++;
      $display("FAIL inline_lu_hazard actual=%h required=%h", loadUseHazard, 1'b1);
    end
    stall = 1;
    tick();
    expect_val("lu_stall_exValid", S_VAL, 1);
    expect_val("lu_stall_exMemRead", S_MR, 1);
    expect_val("lu_stall_luh", S_LUH, 1);
    expect_val("lu_stall_bubbles", S_BC, 0);
    sample();
    stall = 0;
    tick();
    expect_val("lu_bubble_exValid", S_VAL, 0);
    expect_val("lu_bubble_exRegWrite", S_RW, 0);
    expect_val("lu_bubble_luh", S_LUH, 0);
`ifdef ID_EX_PERF_CNT_EN
    expect_val("bubbleCount", S_BC, 1);
`endif
    sample();
    checks++;
    if (exValid !== 1'b0) begin
      failures++;
      $display("FAIL inline_lu_bubble_exValid actual=%h required=%h", exValid, 1'b0);
    end
    tick();
    expect_val("lu_after_exValid", S_VAL, 1);
    expect_val("lu_after_exWriteReg", S_WR, 8);
    expect_val("lu_after_aluInA", S_A, 32'h44);
    sample();

    drive_id(1, 5'd2, 32'h2, 5'd3, 32'h3, 5'd11, 1, 0, 32'd0, 3'b011, 1, 0);
    flush = 1; stall = 1;
    tick();
    flush = 0; stall = 0;
    expect_val("flush_exValid", S_VAL, 0);
    expect_val("flush_exRegWrite", S_RW, 0);
`ifdef ID_EX_PERF_CNT_EN
    expect_val("flushCount", S_FC, 1);
    expect_val("bubbleCount_hold", S_BC, 1);
`endif
    sample();
    checks++;
    if (exRegWrite !== 1'b0) begin
      failures++;
      $display("FAIL inline_flush_exRegWrite actual=%h required=%h", exRegWrite, 1'b0);
    end

    clrCounts = 1;
    tick();
    clrCounts = 0;
    expect_val("reload_exValid", S_VAL, 1);
    expect_val("reload_aluOp", S_OP, 3);
`ifdef ID_EX_PERF_CNT_EN
    expect_val("clr_flushCount", S_FC, 0);
    expect_val("clr_bubbleCount", S_BC, 0);
`endif
    sample();
    #1 rstN = 1'b0;
    expect_val("async_rst_exValid", S_VAL, 0);
    expect_val("async_rst_exRegWrite", S_RW, 0);
    expect_val("async_rst_aluOp", S_OP, 0);
    sample();
    checks++;
    if (aluOp !== 3'b000) begin
      failures++;
      $display("FAIL inline_async_rst_aluOp actual=%h required=%h", aluOp, 3'b000);
    end
    rstN = 1'b1;

    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
